// File: rtl/twiddle_request_sequencer_pkg.sv
// twiddle_request_sequencer_pkg: shared FSM states and float/fixed-point constants
package twiddle_request_sequencer_pkg;
    localparam int FLT_EXP_W   = 8;
    localparam int FLT_MANT_W  = 23;
    localparam int FLOAT_BIAS  = 127;
    localparam int Q_FRAC_BITS = 16;
    typedef enum logic [1:0] {IDLE, ISSUE_COS, ISSUE_SIN, DRAIN} state_t;
endpackage

// File: rtl/twiddle_request_sequencer_if.sv
// twiddle_request_sequencer_if: control, calculator and twiddle-stream signals of the sequencer
interface twiddle_request_sequencer_if #(
    parameter int PHASE_W  = 19,
    parameter int MAX_LOG2 = 10,
    parameter int FW       = 32
);
    logic                start;
    logic [3:0]          n_log2;
    logic [PHASE_W-1:0]  theta_step;
    logic                inverse;
    logic                calc_enable;
    logic [FW-1:0]       calc_theta;
    logic                calc_sine_cosine;
    logic [FW-1:0]       calc_value;
    logic                tw_valid;
    logic                tw_ready;
    logic [FW-1:0]       tw_cos;
    logic [FW-1:0]       tw_sin;
    logic [MAX_LOG2-1:0] tw_index;
    logic                busy;
    logic                done;
    modport slave (
        input  start, n_log2, theta_step, inverse, calc_value, tw_ready,
        output calc_enable, calc_theta, calc_sine_cosine, tw_valid, tw_cos, tw_sin, tw_index, busy, done
    );
    modport master (
        output start, n_log2, theta_step, inverse, calc_value, tw_ready,
        input  calc_enable, calc_theta, calc_sine_cosine, tw_valid, tw_cos, tw_sin, tw_index, busy, done
    );
endinterface

// File: rtl/twiddle_request_sequencer_q_to_float.sv
// q_to_float: combinational unsigned Q3.16 phase to single-precision float with external sign
module q_to_float
    import twiddle_request_sequencer_pkg::*;
#(
    parameter int PHASE_W      = 19,
    parameter int EXP_LEN      = FLT_EXP_W,
    parameter int MANTISSA_LEN = FLT_MANT_W
) (
    input  logic [PHASE_W-1:0]          i_phase,
    input  logic                        i_sign,
    output logic [EXP_LEN+MANTISSA_LEN:0] o_float
);
    localparam int PBW = $clog2(PHASE_W);
    logic [PBW-1:0]                  w_p;
    logic [PHASE_W+MANTISSA_LEN-1:0] w_norm;
    always_comb begin
        w_p = '0;
        for (int i = 0; i < PHASE_W; i++) if (i_phase[i]) w_p = PBW'(i);
        w_norm  = {i_phase, {MANTISSA_LEN{1'b0}}} << (PBW'(PHASE_W - 1) - w_p);
        o_float = (i_phase == '0) ? {i_sign, {(EXP_LEN+MANTISSA_LEN){1'b0}}}
                : {i_sign, EXP_LEN'(FLOAT_BIAS - Q_FRAC_BITS + int'(w_p)), w_norm[PHASE_W+MANTISSA_LEN-2 -: MANTISSA_LEN]};
    end
endmodule

// File: rtl/twiddle_request_sequencer.sv
// twiddle_request_sequencer: issues cos/sin requests per index under FIFO credit and streams paired results
module twiddle_request_sequencer
    import twiddle_request_sequencer_pkg::*;
#(
    parameter int EXP_LEN      = FLT_EXP_W,
    parameter int MANTISSA_LEN = FLT_MANT_W,
    parameter int CALC_LATENCY = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int PHASE_W      = 19,
    parameter int MAX_LOG2     = 10
) (
    input logic clk,
    input logic rst_n,
    twiddle_request_sequencer_if.slave bus
);
    localparam int FW = 1 + EXP_LEN + MANTISSA_LEN;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    state_t                  r_state, w_next;
    logic [3:0]              r_n_log2;
    logic [PHASE_W-1:0]      r_step, r_phase;
    logic                    r_inv;
    logic [MAX_LOG2-1:0]     r_k, r_push_idx, w_last;
    logic [CALC_LATENCY-1:0] r_vld_sr, r_sel_sr;
    logic [FW-1:0]           r_cos_hold, w_theta;
    logic [MAX_LOG2-1:0]     r_fifo_idx [FIFO_DEPTH];
    logic [FW-1:0]           r_fifo_cos [FIFO_DEPTH];
    logic [FW-1:0]           r_fifo_sin [FIFO_DEPTH];
    logic [PW-1:0]           r_wr, r_rd;
    logic [CW-1:0]           r_count, r_pairs;
    logic                    w_credit, w_en, w_sel, w_start, w_push, w_pop, w_valid, w_drained;

    q_to_float #(.PHASE_W(PHASE_W), .EXP_LEN(EXP_LEN), .MANTISSA_LEN(MANTISSA_LEN)) u_q2f (
        .i_phase(r_phase), .i_sign(r_inv), .o_float(w_theta)
    );

    // a pair holds one credit from its cos issue until its sin result lands in the FIFO
    assign w_credit  = (32'(r_pairs) + 32'(r_count)) < 32'(FIFO_DEPTH);
    assign w_last    = (MAX_LOG2'(1) << r_n_log2) - 1'b1;
    assign w_start   = (r_state == IDLE) && bus.start;
    assign w_push    = r_vld_sr[CALC_LATENCY-1] && r_sel_sr[CALC_LATENCY-1];
    assign w_valid   = r_count != '0;
    assign w_pop     = w_valid && bus.tw_ready;
    assign w_drained = (r_vld_sr == '0) && (r_count == '0);

    always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        w_en   = 1'b0;
        w_sel  = 1'b0;
        case (r_state)
            IDLE:      w_next = bus.start ? ISSUE_COS : IDLE;
            ISSUE_COS: begin
                w_en   = w_credit;
                w_next = w_credit ? ISSUE_SIN : ISSUE_COS;
            end
            ISSUE_SIN: begin
                w_en   = 1'b1;
                w_sel  = 1'b1;
                w_next = (r_k < w_last) ? ISSUE_COS : DRAIN;
            end
            DRAIN:     w_next = w_drained ? IDLE : DRAIN;
            default:   w_next = IDLE;
        endcase
    end

    assign bus.calc_enable      = w_en;
    assign bus.calc_theta       = w_en ? w_theta : '0;
    assign bus.calc_sine_cosine = w_sel;
    assign bus.busy             = r_state != IDLE;
    assign bus.done             = (r_state == DRAIN) && w_drained;
    assign bus.tw_valid         = w_valid;
    assign bus.tw_cos           = w_valid ? r_fifo_cos[r_rd] : '0;
    assign bus.tw_sin           = w_valid ? r_fifo_sin[r_rd] : '0;
    assign bus.tw_index         = w_valid ? r_fifo_idx[r_rd] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n_log2   <= '0;
            r_step     <= '0;
            r_inv      <= 1'b0;
            r_phase    <= '0;
            r_k        <= '0;
            r_push_idx <= '0;
            r_vld_sr   <= '0;
            r_sel_sr   <= '0;
            r_cos_hold <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_pairs    <= '0;
        end else begin
            r_vld_sr <= {r_vld_sr[CALC_LATENCY-2:0], w_en};
            r_sel_sr <= {r_sel_sr[CALC_LATENCY-2:0], w_sel};
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_pairs  <= r_pairs + CW'(w_en && !w_sel) - CW'(w_push);
            if (w_start) begin
                r_n_log2   <= bus.n_log2;
                r_step     <= bus.theta_step;
                r_inv      <= bus.inverse;
                r_phase    <= '0;
                r_k        <= '0;
                r_push_idx <= '0;
            end
            if (w_en && w_sel) begin
                r_phase <= r_phase + r_step;
                r_k     <= r_k + 1'b1;
            end
            if (r_vld_sr[CALC_LATENCY-1] && !r_sel_sr[CALC_LATENCY-1]) r_cos_hold <= bus.calc_value;
            if (w_push) begin
                r_wr       <= r_wr + 1'b1;
                r_push_idx <= (r_push_idx == w_last) ? '0 : r_push_idx + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr] <= r_push_idx;
            r_fifo_cos[r_wr] <= r_cos_hold;
            r_fifo_sin[r_wr] <= bus.calc_value;
        end
    end

    always_ff @(posedge clk) if (rst_n && w_push && !w_pop) assert (r_count != CW'(FIFO_DEPTH));
endmodule

// File: doc/twiddle_request_sequencer.md
TWIDDLE_REQUEST_SEQUENCER -- requirements
Module: twiddle_request_sequencer

Interface
REQ-001 SHALL have parameters: EXP_LEN, 8, float exponent width; MANTISSA_LEN, 23, float mantissa width; CALC_LATENCY, 3, cycles from calc_enable to calc_value valid; FIFO_DEPTH, 4, buffered cos/sin pairs; PHASE_W, 19, unsigned Q3.16 phase width; MAX_LOG2, 10, largest log2 point count.
REQ-002 SHALL have ports: clk in 1 clock; rst_n in 1 synchronous active-low reset; one clock, all logic on rising clk.
REQ-003 SHALL have ports: start in 1 begin sequence; n_log2 in 4 log2 of point count N (1..MAX_LOG2); theta_step in PHASE_W Q3.16 radians per index; inverse in 1 negate theta.
REQ-004 SHALL have ports: calc_enable out 1; calc_theta out 1+EXP_LEN+MANTISSA_LEN float theta; calc_sine_cosine out 1 (0=cos, 1=sin); calc_value in 1+EXP_LEN+MANTISSA_LEN calculator result.
REQ-005 SHALL have ports: tw_valid out 1; tw_ready in 1; tw_cos out 32; tw_sin out 32; tw_index out MAX_LOG2; busy out 1; done out 1 one-cycle pulse.

Function
REQ-006 SHALL use FSM states IDLE, ISSUE_COS, ISSUE_SIN, DRAIN; IDLE->ISSUE_COS on start; ISSUE_COS->ISSUE_SIN when a request issues; ISSUE_SIN->ISSUE_COS if k<N-1 else DRAIN; DRAIN->IDLE when no request is in flight and the FIFO is empty.
REQ-007 SHALL latch n_log2, theta_step and inverse on start in IDLE; SHALL ignore start outside IDLE.
REQ-008 SHALL keep phase accumulator phase=k*theta_step modulo 2^PHASE_W, cleared on start, incremented by theta_step after each ISSUE_SIN issue.
REQ-009 SHALL convert phase to float combinationally: zero -> exponent and mantissa all zeros; else leading-one position p -> exponent 111+p, mantissa the bits below p left-aligned into MANTISSA_LEN bits, zero-filled; sign = inverse.
REQ-010 SHALL issue a request (calc_enable=1, theta, select) only when the pairs in flight plus FIFO occupancy are less than FIFO_DEPTH, counting each cos/sin pair as one from its ISSUE_COS issue; else calc_enable=0 and the state holds.
REQ-011 SHALL track in-flight requests with a CALC_LATENCY-deep valid/select shift register and capture calc_value exactly CALC_LATENCY cycles after issue; a cos result SHALL be held, and the following sin result SHALL push {index, cos, sin} into the FIFO.
REQ-012 SHALL present the FIFO head on tw_*; tw_valid=1 while non-empty; pop on tw_valid&&tw_ready; a simultaneous push and pop SHALL keep occupancy unchanged.
REQ-013 SHALL never overflow the FIFO; credit per REQ-010 guarantees it; an overflow attempt is a design error flagged by assertion.
REQ-014 SHALL wrap tw_index at N-1 and terminate; SHALL pulse done one cycle on DRAIN->IDLE; busy=1 in every state but IDLE.
REQ-015 SHALL hold calc_theta and calc_sine_cosine at 0 when calc_enable=0.

Reset
REQ-016 On rst_n=0 at clk SHALL enter IDLE and clear phase, k, the in-flight shift register, FIFO pointers and occupancy, and latched config; outputs calc_enable=0, calc_theta=0, calc_sine_cosine=0, tw_valid=0, tw_cos=0, tw_sin=0, tw_index=0, busy=0, done=0.
REQ-017 Reset mid-sequence SHALL discard in-flight results; calc_value arriving after reset SHALL be ignored.

Structure
REQ-018 A shared package SHALL hold the FSM state enum, float field widths, the float exponent bias 127, and the Q3.16 fraction-bit constant 16.
REQ-019 The fixed-to-float converter SHALL be one sub-module, q_to_float, purely combinational; FIFO inline.

Verification
REQ-020 Bench SHALL model the calculator as a CALC_LATENCY pipeline returning theta|select.
REQ-021 n_log2=2, theta_step=0x08000, inverse=0, tw_ready=1 -> calc_theta 0x00000000, 0x3F000000, 0x3F800000, 0x3FC00000 (each twice, cos then sin); tw_index 0..3; done once.
REQ-022 Same with inverse=1 -> thetas 0x80000000, 0xBF000000, 0xBF800000, 0xBFC00000.
REQ-023 n_log2=4, tw_ready=0 for 20 cycles -> at most 4 pairs buffered, calc_enable low while credit exhausted, all 16 indices delivered in order, none lost.
REQ-024 start pulsed while busy -> ignored; sequence output identical to REQ-021.
REQ-025 rst_n low at the 5th issue -> all outputs at reset values next cycle; later calc_value ignored; new start runs clean.
REQ-026 theta_step=0x7FFFF, n_log2=1 -> k=1 theta 0x40FFFFE0 (p=18).
